// File: rtl/bus_rr_sched.sv
// Round-robin scheduler for a shared packet bus: grants one pending driver port at a time,
// pops its head packet and routes it to the destination port(s) on a single D_push bus.
module bus_rr_sched #(
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [drvrs-1:0]         pndng,
   input  logic [drvrs*pckg_sz-1:0] D_pop,
   output logic [drvrs-1:0]         pop,
   output logic [drvrs-1:0]         push,
   output logic [pckg_sz-1:0]       D_push,
   output logic                     busy,
   output logic                     err_dst,
   output logic [15:0]              pkt_cnt
);

   localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam logic [drvrs-1:0] LSB = {{(drvrs-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, GRANT, DRIVE} state_t;

   state_t             state;
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      g;
   logic [PW-1:0]      next_g;
   logic [PW-1:0]      g_inc;
   logic [PW-1:0]      cand;
   logic               found;
   logic [pckg_sz-1:0] pkt_q;
   logic [pckg_sz-1:0] head;
   logic [7:0]         dst;
   logic               dst_ok;
   logic               dst_bc;
   logic [drvrs-1:0]   g_onehot;

   // Rotating search starting at rr_ptr; the first pending port in that order wins.
   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      next_g = rr_ptr;
      found  = 1'b0;
      cand   = rr_ptr;
      for (int k = 0; k < drvrs; k++) begin
         cand = (int'(rr_ptr) + k >= drvrs) ? PW'(int'(rr_ptr) + k - drvrs)
                                            : PW'(int'(rr_ptr) + k);
         if (!found && pndng[cand]) begin
            next_g = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      head = D_pop[pckg_sz-1:0];
      for (int k = 1; k < drvrs; k++) begin
         if (g == PW'(k)) head = D_pop[k*pckg_sz +: pckg_sz];
      end
   end

   assign g_inc    = (g == PW'(drvrs-1)) ? '0 : g + PW'(1);
   assign g_onehot = LSB << g;
   assign dst      = pkt_q[pckg_sz-1 -: 8];
   assign dst_ok   = dst < 8'(drvrs);
   assign dst_bc   = dst == broadcast;
   assign busy     = state != IDLE;

   always_comb begin
      pop     = '0;
      push    = '0;
      D_push  = '0;
      err_dst = 1'b0;
      if (state == GRANT && pndng[g]) pop = g_onehot;
      if (state == DRIVE) begin
         D_push = pkt_q;
         if (dst_ok)      push    = LSB << dst[PW-1:0];
         else if (dst_bc) push    = ~g_onehot;
         else             err_dst = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         g       <= '0;
         pkt_q   <= '0;
         pkt_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|pndng) begin
                  g     <= next_g;
                  state <= GRANT;
               end
            end
            GRANT: begin
               // A withdrawn request returns to IDLE without touching the pointer.
               if (pndng[g]) begin
                  pkt_q <= head;
                  state <= DRIVE;
               end else begin
                  state <= IDLE;
               end
            end
            DRIVE: begin
               pkt_cnt <= pkt_cnt + 16'd1;
               rr_ptr  <= g_inc;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_rr_sched.sv
// Self-checking bench for bus_rr_sched: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_bus_rr_sched;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   pndng;
   logic [N*W-1:0] D_pop;
   logic [N-1:0]   pop;
   logic [N-1:0]   push;
   logic [W-1:0]   D_push;
   logic           busy;
   logic           err_dst;
   logic [15:0]    pkt_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_rr_sched #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
      .D_push(D_push), .busy(busy), .err_dst(err_dst), .pkt_cnt(pkt_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: m_src is the port currently being served (-1 when none),
   // m_have says its packet has been taken, m_ptr is the port that gets first look next.
   int          m_src  = -1;
   bit          m_have = 1'b0;
   logic [15:0] m_pkt  = '0;
   int          m_ptr  = 0;
   logic [15:0] m_cnt  = '0;
   int          m_c;
   logic [3:0]  e_pop, e_push;
   logic [15:0] e_dpush;
   logic        e_err;
   logic [7:0]  e_dst;

   always @(negedge clk) begin
      e_pop   = '0;
      e_push  = '0;
      e_dpush = '0;
      e_err   = 1'b0;
      if (m_src >= 0 && !m_have && pndng[m_src[1:0]]) e_pop = 4'(1 << m_src);
      if (m_have) begin
         e_dst   = m_pkt[15:8];
         e_dpush = m_pkt;
         if (e_dst < N)            e_push = 4'(1 << e_dst);
         else if (e_dst == 8'hFF)  e_push = 4'hF & ~4'(1 << m_src);
         else                      e_err  = 1'b1;
      end
      check("pop",     32'(pop),     32'(e_pop));
      check("push",    32'(push),    32'(e_push));
      check("D_push",  32'(D_push),  32'(e_dpush));
      check("err_dst", 32'(err_dst), 32'(e_err));
      check("busy",    32'(busy),    32'(m_src >= 0));
      check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));

      if (reset) begin
         m_src = -1; m_have = 1'b0; m_pkt = '0; m_ptr = 0; m_cnt = '0;
      end else if (m_have) begin
         m_cnt  = m_cnt + 16'd1;
         m_ptr  = (m_src + 1) % N;
         m_src  = -1;
         m_have = 1'b0;
      end else if (m_src >= 0) begin
         if (pndng[m_src[1:0]]) begin
            m_pkt  = D_pop[m_src*W +: W];
            m_have = 1'b1;
         end else begin
            m_src = -1;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            m_c = (m_ptr + k) % N;
            if (m_src < 0 && pndng[m_c[1:0]]) m_src = m_c;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int p, input logic [15:0] v);
      D_pop[p*W +: W] = v;
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      pndng = '0;
      step();
      reset = 1'b0;
   endtask

   logic [7:0] r_dst;
   int         r_sel;

   initial begin
      reset = 1'b1;
      pndng = '1;
      D_pop = '0;

      // Reset held with every port pending: nothing moves.
      repeat (2) begin
         step();
         @(negedge clk);
         check("rst_pop",  32'(pop),     32'h0);
         check("rst_push", 32'(push),    32'h0);
         check("rst_busy", 32'(busy),    32'h0);
         check("rst_cnt",  32'(pkt_cnt), 32'h0);
      end
      step();

      // Unicast from port 1 to port 2.
      reset = 1'b0;
      pndng = 4'b0010;
      put(1, 16'h02AB);
      step();
      @(negedge clk);
      check("uni_pop", 32'(pop), 32'h2);
      step();
      pndng = '0;
      @(negedge clk);
      check("uni_push",  32'(push),   32'h4);
      check("uni_data",  32'(D_push), 32'h02AB);
      step();
      @(negedge clk);
      check("uni_cnt", 32'(pkt_cnt), 32'd1);

      // Round robin with all ports continuously pending.
      do_reset();
      for (int p = 0; p < N; p++) put(p, {8'h00, 8'(p)});
      pndng = '1;
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         check("rr_pop", 32'(pop), 32'(1 << (i % N)));
         step();
         @(negedge clk);
         check("rr_push", 32'(push), 32'h1);
         step();
      end
      pndng = '0;
      @(negedge clk);
      check("rr_cnt", 32'(pkt_cnt), 32'd5);

      // Broadcast from port 2.
      step();
      pndng = 4'b0100;
      put(2, 16'hFF5A);
      step();
      @(negedge clk);
      check("bc_pop", 32'(pop), 32'h4);
      step();
      pndng = '0;
      @(negedge clk);
      check("bc_push", 32'(push),    32'hB);
      check("bc_data", 32'(D_push),  32'hFF5A);
      check("bc_err",  32'(err_dst), 32'h0);
      step();

      // Destination outside the port range.
      pndng = 4'b0001;
      put(0, 16'h0711);
      step();
      @(negedge clk);
      check("bad_pop", 32'(pop), 32'h1);
      step();
      pndng = '0;
      @(negedge clk);
      check("bad_push", 32'(push),    32'h0);
      check("bad_err",  32'(err_dst), 32'h1);
      step();
      @(negedge clk);
      check("bad_err_end", 32'(err_dst), 32'h0);
      check("bad_cnt",     32'(pkt_cnt), 32'd7);

      // Withdrawn request during grant.
      step();
      pndng = 4'b1000;
      step();
      pndng = '0;
      @(negedge clk);
      check("wd_pop",  32'(pop),  32'h0);
      check("wd_busy", 32'(busy), 32'h1);
      step();
      @(negedge clk);
      check("wd_idle", 32'(busy),    32'h0);
      check("wd_cnt",  32'(pkt_cnt), 32'd7);

      // Reset arriving while a packet is on the bus.
      step();
      pndng = 4'b1000;
      put(3, 16'h01CC);
      step();
      @(negedge clk);
      check("rd_pop", 32'(pop), 32'h8);
      step();
      pndng = '0;
      reset = 1'b1;
      @(negedge clk);
      check("rd_push", 32'(push), 32'h2);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rd_push_after", 32'(push),    32'h0);
      check("rd_cnt_after",  32'(pkt_cnt), 32'h0);
      check("rd_busy_after", 32'(busy),    32'h0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         step();
         reset = ($urandom_range(0, 199) == 0);
         pndng = 4'($urandom) | 4'($urandom);
         for (int p = 0; p < N; p++) begin
            r_sel = $urandom_range(0, 9);
            if (r_sel < 6)      r_dst = 8'(r_sel % N);
            else if (r_sel < 8) r_dst = 8'hFF;
            else                r_dst = 8'($urandom_range(N, 254));
            put(p, {r_dst, 8'($urandom)});
         end
      end

      step();
      reset = 1'b0;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
